uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
// Receive-side controller for the 3-data-bit UART receiver. Generates the 16x oversampling tick,
// takes each completed frame (rx_done, data, parity), checks parity and buffers frames in a
// small FIFO. Frames leave on a valid/ready port. Sticky parity-error and overflow status is kept.
// PARAMETERS
// DBITS     3   data bits per frame; must match the receiver
// DEPTH     4   FIFO entries; power of 2, >= 2
// DIV_W     16  width of baud_div
// DROP_BAD  0   1: frames with a parity error are discarded, not written to the FIFO
// PORTS
// clk        in   1      system clock
// rst        in   1      synchronous, active-high reset
// en         in   1      1: tick generator and frame capture run
// baud_div   in   DIV_W  clk cycles per tick (16x baud); 0 and 1 both mean a tick every cycle
// parity_odd in   1      0: even parity, 1: odd parity
// tick       out  1      one-cycle oversampling strobe to the receiver
// rx_done    in   1      receiver frame-complete pulse
// rx_data    in   DBITS  receiver dout; sampled when rx_done=1
// rx_parity  in   1      receiver parity_o; sampled when rx_done=1
// m_valid    out  1      FIFO head is valid
// m_data     out  DBITS  FIFO head data
// m_perr     out  1      FIFO head parity-error flag
// m_ready    in   1      consumer accepts the head (pop when m_valid & m_ready)
// flush      in   1      one-cycle pulse; empties the FIFO
// clr_err    in   1      clears perr_sticky and ovf_sticky
// perr_sticky out 1      set by any frame with a parity error
// ovf_sticky  out 1      set when a frame is lost because the FIFO is full
// level      out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
// Reset (rst=1 at a clk edge): tick=0, m_valid=0, level=0, both sticky flags 0, divider count 0,
//   FIFO pointers 0. Reset during an operation discards all buffered frames on the next edge.
// Tick generator: registered divider count. When en=1, count runs 0..baud_div-1 and wraps.
//   tick=1 for the one cycle in which count==baud_div-1. baud_div<=1 gives tick=1 on every cycle.
//   When en=0, count is forced to 0 and tick=0.
//   A baud_div change takes effect at the next wrap. If count>=new div-1, the count wraps immediately.
// Parity: err = (^rx_data ^ rx_parity) != parity_odd, evaluated in the rx_done cycle.
// Capture: when rx_done=1 and en=1, frame {err, rx_data} is written. It is not written when DROP_BAD=1 and err=1.
//   rx_done is ignored when en=0.
// FIFO: show-ahead. m_valid=(level!=0). m_data/m_perr come from the head entry and are stable while m_valid=1 and m_ready=0.
//   Latency: write at edge N -> m_valid=1 after edge N when the FIFO was empty.
//   Push and pop in the same cycle: both happen, including when the FIFO is full. level is unchanged.
//   Push when full without a pop: frame is dropped, ovf_sticky<=1, FIFO contents are unchanged.
//   Pointers are log2(DEPTH) bits and wrap naturally; full/empty are taken from level.
// flush: FIFO is emptied. Flush has priority over a push or pop in the same cycle, so that frame is lost.
//   Frame loss caused by flush does not set ovf_sticky.
// Sticky flags: perr_sticky<=1 on any err frame, including a dropped one.
//   Set has priority over clr_err in the same cycle.
// Control: 2-state FSM. OFF: en=0; no tick and no capture. RUN: en=1.
//   OFF->RUN happens on en=1, with count restarting at 0. RUN->OFF happens on en=0.
//   Buffered data is kept across OFF, so the consumer can still drain it.
// STRUCTURE
// uart_pkg: DBITS, typedef frame_t = struct packed {logic perr; logic [DBITS-1:0] data;},
//   typedef enum {OFF, RUN} ctrl_state_t.
// Sub-module uart_rx_fifo (frame_t entries; DEPTH; push/pop/flush/level; show-ahead head).
// Top holds the divider, parity check, sticky flags and FSM. Target size: 150-250 lines total.
// TESTING
// 1 baud_div=4, en=1 for 20 cycles -> tick=1 on cycles 4,8,12,16,20 only. en=0 -> tick stays 0.
// 2 parity_odd=0, rx_data=3'b101, rx_parity=0, rx_done pulse -> next cycle m_valid=1, m_data=5, m_perr=0, perr_sticky=0.
// 3 Same frame with rx_parity=1 -> m_perr=1, perr_sticky=1. With DROP_BAD=1 -> m_valid stays 0 and perr_sticky=1.
// 4 Write 5 frames (1..5), m_ready=0 -> level=4, ovf_sticky=1. Drain -> data 1,2,3,4 in order, then m_valid=0.
// 5 FIFO full, rx_done and m_ready both 1 in one cycle -> level stays 4, ovf_sticky stays 0, new frame is at the tail.
// 6 level=3, pulse flush with a simultaneous rx_done -> level=0. Assert rst mid-stream -> all outputs return to reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receive-side controller: frame layout and control FSM states.
package uart_pkg;

    localparam int DBITS = 3;

    typedef struct packed {
        logic             perr;
        logic [DBITS-1:0] data;
    } frame_t;

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead frame FIFO: head entry is visible on `head` whenever `valid` is high.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  frame_t                     push_frame,
    input  logic                       pop,
    input  logic                       flush,
    output frame_t                     head,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    frame_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            do_push, do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign valid = (level_q != '0);
    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

    // A push into a full FIFO only succeeds when a pop frees the head slot in the same cycle.
    assign do_push = push & ~flush & (~full | pop);
    assign do_pop  = pop  & ~flush & valid;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; level_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_frame;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x tick divider, parity check, frame FIFO and sticky status flags.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DIV_W    = 16,
    parameter int DROP_BAD = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DIV_W-1:0]       baud_div,
    input  logic                   parity_odd,
    output logic                   tick,
    input  logic                   rx_done,
    input  logic [DBITS-1:0]       rx_data,
    input  logic                   rx_parity,
    output logic                   m_valid,
    output logic [DBITS-1:0]       m_data,
    output logic                   m_perr,
    input  logic                   m_ready,
    input  logic                   flush,
    input  logic                   clr_err,
    output logic                   perr_sticky,
    output logic                   ovf_sticky,
    output logic [$clog2(DEPTH):0] level
);

    ctrl_state_t      state_q, state_d;
    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_m1;
    logic             perr_q, perr_d;
    logic             ovf_q, ovf_d;
    logic             active, wrap, err, capture, push, pop, fifo_full;
    frame_t           head;

    always_comb begin
        state_d = state_q;
        active  = 1'b0;
        unique case (state_q)
            OFF: if (en) begin
                state_d = RUN;
                active  = ~rst;
            end
            RUN: if (!en) state_d = OFF;
                 else     active  = ~rst;
            default: state_d = OFF;
        endcase
    end

    // Divisor 0 and 1 both collapse to a terminal count of 0; >= lets a shrunk divisor wrap at once.
    assign div_m1  = (baud_div <= DIV_W'(1)) ? '0 : baud_div - DIV_W'(1);
    assign wrap    = (count_q >= div_m1);
    assign tick    = active & wrap;
    assign count_d = (active && !wrap) ? count_q + DIV_W'(1) : '0;

    assign err     = ((^rx_data) ^ rx_parity) != parity_odd;
    assign capture = active & rx_done;
    assign push    = capture & ~((DROP_BAD != 0) & err);
    assign pop     = m_valid & m_ready;

    always_comb begin
        perr_d = perr_q;
        ovf_d  = ovf_q;
        if (clr_err) begin
            perr_d = 1'b0;
            ovf_d  = 1'b0;
        end
        if (capture && err)                          perr_d = 1'b1;
        if (push && fifo_full && !pop && !flush)     ovf_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            count_q <= '0;
            perr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            perr_q  <= perr_d;
            ovf_q   <= ovf_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_frame ('{perr: err, data: rx_data}),
        .pop        (pop),
        .flush      (flush),
        .head       (head),
        .valid      (m_valid),
        .full       (fifo_full),
        .level      (level)
    );

    assign m_data      = head.data;
    assign m_perr      = head.perr;
    assign perr_sticky = perr_q;
    assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a keep-bad instance and a DROP_BAD=1 instance share the stimulus.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, parity_odd, rx_done, rx_parity, m_ready, flush, clr_err;
    logic [15:0] baud_div;
    logic [2:0]  rx_data;

    logic        tick, m_valid, m_perr, perr_sticky, ovf_sticky;
    logic [2:0]  m_data;
    logic [2:0]  level;
    logic        d_tick, d_valid, d_perr, d_perr_sticky, d_ovf_sticky;
    logic [2:0]  d_data;
    logic [2:0]  d_level;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(4), .DIV_W(16), .DROP_BAD(0)) dut (
        .clk(clk), .rst(rst), .en(en), .baud_div(baud_div), .parity_odd(parity_odd),
        .tick(tick), .rx_done(rx_done), .rx_data(rx_data), .rx_parity(rx_parity),
        .m_valid(m_valid), .m_data(m_data), .m_perr(m_perr), .m_ready(m_ready),
        .flush(flush), .clr_err(clr_err), .perr_sticky(perr_sticky),
        .ovf_sticky(ovf_sticky), .level(level)
    );

    uart_rx_ctrl #(.DEPTH(4), .DIV_W(16), .DROP_BAD(1)) dut_drop (
        .clk(clk), .rst(rst), .en(en), .baud_div(baud_div), .parity_odd(parity_odd),
        .tick(d_tick), .rx_done(rx_done), .rx_data(rx_data), .rx_parity(rx_parity),
        .m_valid(d_valid), .m_data(d_data), .m_perr(d_perr), .m_ready(m_ready),
        .flush(flush), .clr_err(clr_err), .perr_sticky(d_perr_sticky),
        .ovf_sticky(d_ovf_sticky), .level(d_level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Even-parity bit for parity_odd=0 frames.
    function automatic logic good_par(input logic [2:0] d);
        return ^d;
    endfunction

    task automatic send(input logic [2:0] d, input logic p);
        rx_done   = 1'b1;
        rx_data   = d;
        rx_parity = p;
        step();
        rx_done   = 1'b0;
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    int ticks;

    initial begin
        rst = 1'b1; en = 1'b0; baud_div = 16'd4; parity_odd = 1'b0;
        rx_done = 1'b0; rx_data = '0; rx_parity = 1'b0;
        m_ready = 1'b0; flush = 1'b0; clr_err = 1'b0;
        step();
        step();
        check("rst_tick",    tick,        0);
        check("rst_valid",   m_valid,     0);
        check("rst_level",   level,       0);
        check("rst_perr",    perr_sticky, 0);
        check("rst_ovf",     ovf_sticky,  0);
        rst = 1'b0;
        step();

        // Divider: baud_div=4 ticks on cycles 4,8,12,16,20 of the enabled window.
        en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            #1;
            check($sformatf("tick_c%0d", i), tick, (i % 4 == 0) ? 1 : 0);
            step();
        end
        en = 1'b0;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            ticks += int'(tick);
            step();
        end
        check("tick_off", ticks, 0);

        // baud_div 0 and 1 both tick every cycle.
        en = 1'b1; baud_div = 16'd0;
        ticks = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            ticks += int'(tick);
            step();
        end
        baud_div = 16'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            ticks += int'(tick);
            step();
        end
        check("tick_div01", ticks, 6);
        baud_div = 16'd4;

        // rx_done is ignored while disabled.
        en = 1'b0;
        send(3'd3, 1'b0);
        check("cap_off_level", level, 0);
        en = 1'b1;
        step();

        // Good frame 3'b101 with even parity.
        send(3'b101, 1'b0);
        check("good_valid", m_valid,     1);
        check("good_data",  m_data,      5);
        check("good_perr",  m_perr,      0);
        check("good_stky",  perr_sticky, 0);
        check("good_dvld",  d_valid,     1);
        pop_one();
        check("good_popped", level, 0);

        // Same data with wrong parity: kept and flagged, or dropped with DROP_BAD.
        send(3'b101, 1'b1);
        check("bad_valid",  m_valid,       1);
        check("bad_perr",   m_perr,        1);
        check("bad_stky",   perr_sticky,   1);
        check("bad_dvld",   d_valid,       0);
        check("bad_dstky",  d_perr_sticky, 1);
        pop_one();
        clear_err();
        check("clr_perr", perr_sticky, 0);

        // Set wins over a simultaneous clear.
        clr_err = 1'b1;
        send(3'b101, 1'b1);
        clr_err = 1'b0;
        check("set_over_clr", perr_sticky, 1);
        pop_one();
        clear_err();

        // Overflow: five frames into four slots, drain in order.
        for (int k = 1; k <= 5; k++) send(3'(k), good_par(3'(k)));
        check("ovf_level", level,      4);
        check("ovf_flag",  ovf_sticky, 1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain_v%0d", k), m_valid, 1);
            check($sformatf("drain_d%0d", k), m_data,  k);
            pop_one();
        end
        check("drain_empty", m_valid, 0);
        for (int k = 0; k < 4; k++) pop_one();
        clear_err();
        check("clr_ovf", ovf_sticky, 0);

        // Full FIFO with simultaneous push and pop.
        for (int k = 1; k <= 4; k++) send(3'(k), good_par(3'(k)));
        m_ready = 1'b1;
        send(3'd6, good_par(3'd6));
        m_ready = 1'b0;
        check("pp_level", level,      4);
        check("pp_ovf",   ovf_sticky, 0);
        check("pp_head",  m_data,     2);
        pop_one(); pop_one(); pop_one();
        check("pp_tail",  m_data,     6);
        pop_one();
        check("pp_empty", m_valid,    0);

        // Flush beats a simultaneous write and does not count as overflow.
        for (int k = 1; k <= 3; k++) send(3'(k), good_par(3'(k)));
        check("fl_level3", level, 3);
        flush = 1'b1;
        send(3'd7, good_par(3'd7));
        flush = 1'b0;
        check("fl_level", level,      0);
        check("fl_valid", m_valid,    0);
        check("fl_ovf",   ovf_sticky, 0);

        // Reset mid-stream with the divider set to tick every cycle.
        send(3'd1, ~good_par(3'd1));
        send(3'd2, good_par(3'd2));
        check("pre_rst_level", level, 2);
        rst = 1'b1; baud_div = 16'd1;
        step();
        check("mid_rst_tick",  tick,        0);
        check("mid_rst_valid", m_valid,     0);
        check("mid_rst_level", level,       0);
        check("mid_rst_perr",  perr_sticky, 0);
        check("mid_rst_ovf",   ovf_sticky,  0);
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
